// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and types for the multi-port register file.
//   DEF_DW / DEF_DEPTH / DEF_NRD : default data width, register count, read ports
//   clr_state_t                  : clear-sweep FSM state encoding (IDLE=0, SWEEP=1)
package regfile_pkg;

  localparam int DEF_DW    = 32;
  localparam int DEF_DEPTH = 32;
  localparam int DEF_NRD   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } clr_state_t;

endpackage

// File: rtl/regfile_clr_fsm.sv
// regfile_clr_fsm: walks a pointer over every register, one per cycle, so the
// parent can zero the array after a clr_start pulse.
//   clk, reset        : clock, asynchronous active-high reset
//   clr_start         : one-cycle request to start a sweep (ignored while busy)
//   clr_busy          : high for exactly DEPTH cycles while sweeping
//   clr_we / clr_addr : zero-write strobe and target register for this cycle
module regfile_clr_fsm
  import regfile_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr_start,
  output logic          clr_busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  clr_state_t    state, state_n;
  logic [AW-1:0] ptr, ptr_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    case (state)
      IDLE: begin
        if (clr_start) begin
          state_n = SWEEP;
          ptr_n   = '0;
        end
      end
      SWEEP: begin
        // The last entry is still written this cycle; leave afterwards.
        if (ptr == LAST) begin
          state_n = IDLE;
          ptr_n   = '0;
        end else begin
          ptr_n = ptr + AW'(1);
        end
      end
    endcase
  end

  assign clr_busy = (state == SWEEP);
  assign clr_we   = clr_busy;
  assign clr_addr = ptr;

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: register file with NRD combinational read ports, two write
// ports (port 1 wins on conflict), optional write-to-read bypass, optional
// hard-wired zero register, and a sweep that clears every entry.
//   clk, reset                 : clock, asynchronous active-high reset
//   raddr / rdata              : packed read addresses / read data, port i at [i*W +: W]
//   we0/waddr0/wdata0          : write port 0
//   we1/waddr1/wdata1          : write port 1
//   clr_start / clr_busy       : start a clear sweep / sweep in progress
//   wr_drop                    : one-cycle pulse after a write was discarded
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DW      = DEF_DW,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int NRD     = DEF_NRD,
  parameter int BYPASS  = 1,
  parameter int ZERO_R0 = 1,
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NRD*AW-1:0] raddr,
  output logic [NRD*DW-1:0] rdata,
  input  logic              we0,
  input  logic [AW-1:0]     waddr0,
  input  logic [DW-1:0]     wdata0,
  input  logic              we1,
  input  logic [AW-1:0]     waddr1,
  input  logic [DW-1:0]     wdata1,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              wr_drop
);

  function automatic logic in_range(input logic [AW-1:0] a);
    return 32'(a) < DEPTH;
  endfunction

  function automatic logic is_r0(input logic [AW-1:0] a);
    return (ZERO_R0 != 0) && (a == '0);
  endfunction

  logic [DW-1:0] mem [DEPTH];
  logic          clr_we;
  logic [AW-1:0] clr_addr;
  logic          wv0, wv1, drop_n;

  regfile_clr_fsm #(.DEPTH(DEPTH), .AW(AW)) u_clr (
    .clk      (clk),
    .reset    (reset),
    .clr_start(clr_start),
    .clr_busy (clr_busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // Writes to r0 (when hard-wired) vanish silently; out-of-range addresses
  // and anything arriving during a sweep are reported via wr_drop.
  assign wv0    = we0 && !clr_busy && in_range(waddr0) && !is_r0(waddr0);
  assign wv1    = we1 && !clr_busy && in_range(waddr1) && !is_r0(waddr1);
  assign drop_n = (we0 && (clr_busy || !in_range(waddr0))) ||
                  (we1 && (clr_busy || !in_range(waddr1)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) wr_drop <= 1'b0;
    else       wr_drop <= drop_n;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (clr_we && clr_addr == AW'(i))     mem[i] <= '0;
        else if (wv1 && waddr1 == AW'(i))     mem[i] <= wdata1;
        else if (wv0 && waddr0 == AW'(i))     mem[i] <= wdata0;
      end
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0] a;
    logic [DW-1:0] rd;
    assign a = raddr[p*AW +: AW];
    // Forwarding is suppressed during a sweep, when no user write commits.
    always_comb begin
      rd = '0;
      if (!in_range(a) || is_r0(a))                       rd = '0;
      else if ((BYPASS != 0) && !clr_busy && wv1 && waddr1 == a) rd = wdata1;
      else if ((BYPASS != 0) && !clr_busy && wv0 && waddr0 == a) rd = wdata0;
      else                                                rd = mem[a];
    end
    assign rdata[p*DW +: DW] = rd;
  end

endmodule
